// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: runs a 4*NIBBLES-bit addition on an external 4-bit
// combinational adder, one nibble per clock, LSB first, with the carry
// chained between nibbles. The requester sees a start/busy/done handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 request, sampled only while idle
//   a_in, b_in, ci_in     operands and carry-in, latched on acceptance
//   busy                  high while nibbles are being added
//   done                  one-cycle pulse when sum_out/co_out are valid
//   sum_out, co_out       result and final carry, held until next result
//   add_a, add_b, add_ci  drive to the external adder (zero when not running)
//   add_s, add_co         external adder sum and carry-out
//   ovf                   signed overflow of the result, present only when
//                         the SUM_SEQ_OVF_EN macro is defined
module sum_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a_in,
   input  logic [4*NIBBLES-1:0] b_in,
   input  logic                 ci_in,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum_out,
   output logic                 co_out,
`ifdef SUM_SEQ_OVF_EN
   output logic                 ovf,
`endif
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_ci,
   input  logic [3:0]           add_s,
   input  logic                 add_co
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  acc;
   logic [W-1:0]  acc_next;
   logic [IW-1:0] idx;
   logic          carry;

   // Adder inputs are only live while running so the shared adder sees
   // quiet zeros the rest of the time.
   always_comb begin
      add_a  = 4'd0;
      add_b  = 4'd0;
      add_ci = 1'b0;
      if (state == RUN) begin
         add_a  = a_reg[{idx, 2'b00} +: 4];
         add_b  = b_reg[{idx, 2'b00} +: 4];
         add_ci = carry;
      end
   end

   // Accumulator with the current nibble merged in; on the last nibble
   // this is the complete result.
   always_comb begin
      acc_next = acc;
      acc_next[{idx, 2'b00} +: 4] = add_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum_out <= '0;
         co_out  <= 1'b0;
`ifdef SUM_SEQ_OVF_EN
         ovf     <= 1'b0;
`endif
         a_reg   <= '0;
         b_reg   <= '0;
         acc     <= '0;
         idx     <= '0;
         carry   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
                  carry <= ci_in;
                  acc   <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               carry <= add_co;
               if (idx == LAST) begin
                  idx     <= '0;
                  sum_out <= acc_next;
                  co_out  <= add_co;
`ifdef SUM_SEQ_OVF_EN
                  ovf     <= (a_reg[W-1] == b_reg[W-1]) &&
                             (add_s[3] != a_reg[W-1]);
`endif
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// tb_sum_seq_ctrl: directed bench for sum_seq_ctrl with NIBBLES=4.
// Models the external 4-bit adder and checks handshake, results and timing.
module tb_sum_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        ci_in;
   logic        busy;
   logic        done;
   logic [15:0] sum_out;
   logic        co_out;
`ifdef SUM_SEQ_OVF_EN
   logic        ovf;
`endif
   logic [3:0]  add_a;
   logic [3:0]  add_b;
   logic        add_ci;
   logic [3:0]  add_s;
   logic        add_co;

   int checks;
   int failures;

   sum_seq_ctrl #(.NIBBLES(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a_in    (a_in),
      .b_in    (b_in),
      .ci_in   (ci_in),
      .busy    (busy),
      .done    (done),
      .sum_out (sum_out),
      .co_out  (co_out),
`ifdef SUM_SEQ_OVF_EN
      .ovf     (ovf),
`endif
      .add_a   (add_a),
      .add_b   (add_b),
      .add_ci  (add_ci),
      .add_s   (add_s),
      .add_co  (add_co)
   );

   // External combinational 4-bit adder
   assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_ci};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one start pulse and wait (bounded) for done; lat counts
   // negedges from the start-drive negedge to the done negedge.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, output int lat);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      ci_in = ci;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      ci_in = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, co_out} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000", {busy, done, co_out});
      end
      checks++;
      if (sum_out !== 16'h0000) begin
         failures++;
         $display("FAIL reset_sum got=%h exp=0000", sum_out);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({add_a, add_b, add_ci} !== 9'd0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL idle_outputs got=%h/%h/%b busy=%b done=%b exp=0",
                  add_a, add_b, add_ci, busy, done);
      end
   endtask

   task automatic test_basic;
      logic [3:0] exp_a [4];
      logic [3:0] exp_b [4];
      exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
      exp_b = '{4'hC, 4'hB, 4'hA, 4'h0};
      @(negedge clk);
      a_in  = 16'h1234;
      b_in  = 16'h0ABC;
      ci_in = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_in  = 16'hFFFF;
      b_in  = 16'hFFFF;
      ci_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy[%0d] got busy=%b done=%b exp 1/0",
                     k, busy, done);
         end
         checks++;
         if (add_a !== exp_a[k] || add_b !== exp_b[k]) begin
            failures++;
            $display("FAIL basic_nibble[%0d] got=%h/%h exp=%h/%h",
                     k, add_a, add_b, exp_a[k], exp_b[k]);
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_done got done=%b busy=%b exp 1/0", done, busy);
      end
      checks++;
      if (sum_out !== 16'h1CF0 || co_out !== 1'b0) begin
         failures++;
         $display("FAIL basic_sum got=%h co=%b exp=1cf0 co=0", sum_out, co_out);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || sum_out !== 16'h1CF0) begin
         failures++;
         $display("FAIL basic_hold got done=%b sum=%h exp 0/1cf0", done, sum_out);
      end
   endtask

   task automatic test_carry;
      int lat;
      do_op(16'hFFFF, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 5 || sum_out !== 16'h0000 || co_out !== 1'b1) begin
         failures++;
         $display("FAIL carry_wrap got lat=%0d sum=%h co=%b exp 5/0000/1",
                  lat, sum_out, co_out);
      end
      do_op(16'h0005, 16'h000A, 1'b1, lat);
      checks++;
      if (lat !== 5 || sum_out !== 16'h0010 || co_out !== 1'b0) begin
         failures++;
         $display("FAIL carry_in got lat=%0d sum=%h co=%b exp 5/0010/0",
                  lat, sum_out, co_out);
      end
   endtask

   task automatic test_ignore_start;
      int ndone;
      ndone = 0;
      @(negedge clk);
      a_in  = 16'h0001;
      b_in  = 16'h0002;
      ci_in = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a_in  = 16'h1111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      checks++;
      if (ndone !== 1) begin
         failures++;
         $display("FAIL ignore_count got=%0d exp=1", ndone);
      end
      checks++;
      if (sum_out !== 16'h0003) begin
         failures++;
         $display("FAIL ignore_sum got=%h exp=0003", sum_out);
      end
   endtask

   task automatic test_back_to_back;
      int ndone;
      int t [3];
      ndone = 0;
      @(negedge clk);
      a_in  = 16'h0001;
      b_in  = 16'h0001;
      ci_in = 1'b0;
      start = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) begin
            if (ndone < 3) t[ndone] = k;
            ndone++;
         end
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (ndone !== 3) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=3", ndone);
      end else begin
         checks++;
         if (t[1] - t[0] !== 6 || t[2] - t[1] !== 6) begin
            failures++;
            $display("FAIL b2b_period got=%0d,%0d exp=6,6",
                     t[1] - t[0], t[2] - t[1]);
         end
      end
      checks++;
      if (sum_out !== 16'h0002 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_sum got=%h busy=%b exp=0002/0", sum_out, busy);
      end
   endtask

   task automatic test_mid_reset;
      int ndone;
      int lat;
      ndone = 0;
      @(negedge clk);
      a_in  = 16'h1234;
      b_in  = 16'h0ABC;
      ci_in = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || sum_out !== 16'h0000 || add_a !== 4'h0) begin
         failures++;
         $display("FAIL midrst_clear got busy=%b sum=%h add_a=%h exp 0/0000/0",
                  busy, sum_out, add_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      checks++;
      if (ndone !== 0) begin
         failures++;
         $display("FAIL midrst_nodone got=%0d exp=0", ndone);
      end
      do_op(16'h0001, 16'h0001, 1'b0, lat);
      checks++;
      if (lat !== 5 || sum_out !== 16'h0002 || co_out !== 1'b0) begin
         failures++;
         $display("FAIL midrst_after got lat=%0d sum=%h co=%b exp 5/0002/0",
                  lat, sum_out, co_out);
      end
   endtask

`ifdef SUM_SEQ_OVF_EN
   task automatic test_ovf;
      int lat;
      do_op(16'h7FFF, 16'h0001, 1'b0, lat);
      checks++;
      if (ovf !== 1'b1 || co_out !== 1'b0 || sum_out !== 16'h8000) begin
         failures++;
         $display("FAIL ovf_pos got ovf=%b co=%b sum=%h exp 1/0/8000",
                  ovf, co_out, sum_out);
      end
      do_op(16'hFFFF, 16'h0001, 1'b0, lat);
      checks++;
      if (ovf !== 1'b0 || co_out !== 1'b1 || sum_out !== 16'h0000) begin
         failures++;
         $display("FAIL ovf_wrap got ovf=%b co=%b sum=%h exp 0/1/0000",
                  ovf, co_out, sum_out);
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_carry();
      test_ignore_start();
      test_back_to_back();
      test_mid_reset();
`ifdef SUM_SEQ_OVF_EN
      test_ovf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
